share_refresh_unit: RTL and testbench

- Parametrised d-share refresh stage for masked datapaths (Boolean masking, any share count).
- Accepts an N-share WIDTH-bit value and consumes one bundle of num_quad(N) fresh random words. Emits re-masked shares whose XOR equals the input XOR.
- Each random word is added to exactly two shares, one per unordered share pair.
- Sits between masked S-box stages and register/state storage. Valid/ready on all three interfaces, with a 2-entry output buffer for full throughput.

---
 rtl/share_refresh_unit_pkg.sv | 25 ++
 rtl/share_refresh_fifo2.sv | 56 +++++
 rtl/share_refresh_unit.sv | 101 ++++++++++
 tb/tb_share_refresh_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/share_refresh_unit_pkg.sv
// Shared helpers for the share refresh unit: pair enumeration over unordered
// share pairs and the number of random words one refresh consumes.
package share_refresh_unit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // One fresh random word per unordered share pair.
  function automatic int num_quad(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Closed-form index of the unordered pair {i,j}; arguments may come in either order.
  function automatic int pair_index(input int i, input int j, input int n);
    int lo;
    int hi;
    if (i == j) begin
      $error("pair_index: share %0d paired with itself", i);
      return 0;
    end
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return (lo * (2 * n - lo - 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/share_refresh_fifo2.sv
// Two-entry registered FIFO; the head entry is always driven straight from a
// register so downstream never sees a combinational path from the input.
module share_refresh_fifo2 #(
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & (count_q != 2'd2);
  assign pop_ok  = pop & (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mem_q[k] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;

endmodule

// File: rtl/share_refresh_unit.sv
// Boolean-masking refresh stage: each pair of shares receives the same fresh
// random word, so the XOR of all shares is preserved while every share changes.
module share_refresh_unit
  import share_refresh_unit_pkg::*;
#(
  parameter int NUM_SHARES = 3,
  parameter int WIDTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                refresh_en_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [NUM_SHARES*WIDTH-1:0]         in_shares_i,
  input  logic                                rand_valid_i,
  output logic                                rand_ready_o,
  input  logic [num_quad(NUM_SHARES)*WIDTH-1:0] rand_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [NUM_SHARES*WIDTH-1:0]         out_shares_o,
  output logic [CNT_WIDTH-1:0]                refresh_count_o
);

  localparam int SW = NUM_SHARES * WIDTH;

  typedef logic [WIDTH-1:0] bv_w;

  bv_w            pair_word [NUM_SHARES][NUM_SHARES];
  bv_w            mask      [NUM_SHARES];
  logic [SW-1:0]  refreshed;
  logic           space;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           rand_xfer;
  logic [SW:0]    head;
  logic           unused_head_mode;
  logic [1:0]     unused_fill;
  logic [CNT_WIDTH-1:0] count_q;

  // Handshakes: a transfer happens on a side only when its valid and ready are
  // both high in the same cycle; in refresh mode input and random transfer together.
  assign space        = ~fifo_full;
  assign in_ready_o   = space & ~rst_i & (~refresh_en_i | rand_valid_i);
  assign rand_ready_o = space & ~rst_i & refresh_en_i & in_valid_i;
  assign accept       = in_valid_i & in_ready_o;
  assign rand_xfer    = rand_valid_i & rand_ready_o;

  // pair_word[i][j] is the random word shared by shares i and j (zero on the diagonal).
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
      if (i == j) begin : g_diag
        assign pair_word[i][j] = '0;
      end else begin : g_pair
        localparam int P = pair_index(i, j, NUM_SHARES);
        assign pair_word[i][j] = rand_i[P*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    refreshed = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      mask[i] = '0;
      for (int j = 0; j < NUM_SHARES; j++) begin
        mask[i] = mask[i] ^ pair_word[i][j];
      end
      refreshed[i*WIDTH +: WIDTH] = in_shares_i[i*WIDTH +: WIDTH]
                                    ^ (refresh_en_i ? mask[i] : '0);
    end
  end

  share_refresh_fifo2 #(
    .DW(SW + 1)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (accept),
    .pop     (out_valid_o & out_ready_i),
    .wr_data ({refresh_en_i, refreshed}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fill)
  );

  assign out_valid_o = ~fifo_empty;
  assign {unused_head_mode, out_shares_o} = head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (rand_xfer && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign refresh_count_o = count_q;

endmodule

// File: tb/tb_share_refresh_unit.sv
// Directed plus random bench for share_refresh_unit at N=2 (2-bit counter), N=3 and N=5.
module tb_share_refresh_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] refresh_en, in_valid, rand_valid, out_ready;
  wire  [2:0] in_ready, rand_ready, out_valid;
  logic [39:0] in_sh [3];
  logic [79:0] rnd [3];
  wire  [15:0] o2;
  wire  [23:0] o3;
  wire  [39:0] o5;
  wire  [1:0]  c2;
  wire  [31:0] c3, c5;
  logic [39:0] out_sh [3];
  logic [31:0] cnt [3];

  int checks = 0;
  int failures = 0;

  logic [39:0] exp_q0 [$];
  logic [39:0] exp_q1 [$];
  logic [39:0] exp_q2 [$];
  logic [7:0]  xor_q [$];

  always_comb begin
    out_sh[0] = {24'b0, o2};
    out_sh[1] = {16'b0, o3};
    out_sh[2] = o5;
    cnt[0]    = {30'b0, c2};
    cnt[1]    = c3;
    cnt[2]    = c5;
  end

  share_refresh_unit #(.NUM_SHARES(2), .WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .refresh_en_i(refresh_en[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_shares_i(in_sh[0][15:0]),
    .rand_valid_i(rand_valid[0]), .rand_ready_o(rand_ready[0]), .rand_i(rnd[0][7:0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_shares_o(o2),
    .refresh_count_o(c2)
  );

  share_refresh_unit #(.NUM_SHARES(3), .WIDTH(8), .CNT_WIDTH(32)) dut3 (
    .clk_i(clk), .rst_i(rst), .refresh_en_i(refresh_en[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_shares_i(in_sh[1][23:0]),
    .rand_valid_i(rand_valid[1]), .rand_ready_o(rand_ready[1]), .rand_i(rnd[1][23:0]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_shares_o(o3),
    .refresh_count_o(c3)
  );

  share_refresh_unit #(.NUM_SHARES(5), .WIDTH(8), .CNT_WIDTH(32)) dut5 (
    .clk_i(clk), .rst_i(rst), .refresh_en_i(refresh_en[2]),
    .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_shares_i(in_sh[2]),
    .rand_valid_i(rand_valid[2]), .rand_ready_o(rand_ready[2]), .rand_i(rnd[2]),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_shares_o(o5),
    .refresh_count_o(c5)
  );

  // Reference: walk pairs (i<j) in lexicographic order, XOR each word into both shares.
  function automatic logic [39:0] model(input int n, input logic [39:0] sh,
                                        input logic [79:0] r, input logic en);
    logic [39:0] o;
    int p;
    o = sh;
    p = 0;
    if (en) begin
      for (int i = 0; i < n; i++) begin
        for (int j = i + 1; j < n; j++) begin
          o[i*8 +: 8] = o[i*8 +: 8] ^ r[p*8 +: 8];
          o[j*8 +: 8] = o[j*8 +: 8] ^ r[p*8 +: 8];
          p++;
        end
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xor_shares(input logic [39:0] v, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < n; k++) x = x ^ v[k*8 +: 8];
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_exp(input int d, input logic [39:0] e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int d, output logic [39:0] e);
    case (d)
      0:       e = exp_q0.pop_front();
      1:       e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
  endtask

  // Scoreboard side: every output handshake must match the oldest expected entry.
  task automatic mon_pop(input int d);
    logic [39:0] e;
    if (qsize(d) == 0) begin
      checks++;
      failures++;
      $error("FAIL spurious_out_d%0d observed=%0h expected=none", d, out_sh[d]);
    end else begin
      pop_exp(d, e);
      check($sformatf("out_d%0d", d), out_sh[d], e);
      if (d == 2) check("xor_invariant_d2", xor_shares(out_sh[2], 5), xor_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (out_valid[d] && out_ready[d] && !rst) mon_pop(d);
    end
  end

  task automatic send(input int d, input logic [39:0] sh, input logic [79:0] r,
                      input logic en, input logic rv, input logic [39:0] e);
    bit done;
    done = 1'b0;
    in_sh[d] = sh;
    rnd[d] = r;
    refresh_en[d] = en;
    rand_valid[d] = rv;
    in_valid[d] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        done = 1'b1;
        push_exp(d, e);
        if (d == 2) xor_q.push_back(xor_shares(sh, 5));
        check($sformatf("rand_ready_at_accept_d%0d", d), rand_ready[d], en);
      end
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    rand_valid[d] = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL send_timeout_d%0d observed=no_accept expected=accept", d);
    end
  endtask

  task automatic make_rand(input int n, output logic [39:0] sh, output logic [79:0] r);
    sh = '0;
    r = '0;
    for (int k = 0; k < n; k++) sh[k*8 +: 8] = 8'($urandom_range(0, 255));
    for (int k = 0; k < (n * (n - 1)) / 2; k++) r[k*8 +: 8] = 8'($urandom_range(0, 255));
  endtask

  // mode: 0 bypass, 1 refresh, 2 random choice
  task automatic rand_send(input int d, input int n, input int mode);
    logic [39:0] sh;
    logic [79:0] r;
    logic en;
    make_rand(n, sh, r);
    en = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
    send(d, sh, r, en, 1'b1, model(n, sh, r, en));
  endtask

  task automatic wait_drain(input int d);
    for (int k = 0; k < 50 && qsize(d) != 0; k++) @(posedge clk);
    #1;
    check($sformatf("drained_d%0d", d), qsize(d), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] sh_c;
    logic [79:0] r_c;
    logic [39:0] e_c;

    // Clock/reset: an accept attempted during reset must be ignored.
    rst = 1'b1;
    refresh_en = '0; in_valid = '0; rand_valid = '0; out_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin in_sh[d] = '0; rnd[d] = '0; end
    @(posedge clk); #1;
    in_valid = 3'b111; rand_valid = 3'b111;
    in_sh[1] = 40'h0000_123456;
    @(negedge clk);
    check("in_ready_in_reset_d1", in_ready[1], 1'b0);
    check("in_ready_in_reset_d2", in_ready[2], 1'b0);
    check("rand_ready_in_reset_d1", rand_ready[1], 1'b0);
    @(posedge clk); #1;
    in_valid = '0; rand_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 3'b000);
    check("reset_out_shares_d1", out_sh[1], 40'h0);
    check("reset_count_d1", cnt[1], 32'd0);
    @(posedge clk); #1;

    // N=2 directed refresh, then saturation of the 2-bit counter.
    send(0, 40'h5A3C, 80'hFF, 1'b1, 1'b1, 40'hA5C3);
    @(negedge clk);
    check("latency_d0", out_valid[0], 1'b1);
    check("count_after_one_d0", cnt[0], 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rand_send(0, 2, 1);
    wait_drain(0);
    check("count_saturated_d0", cnt[0], 32'd3);

    // N=3 directed refresh.
    send(1, 40'h040201, 80'h402010, 1'b1, 1'b1, 40'h645231);
    @(negedge clk);
    check("latency_d1", out_valid[1], 1'b1);
    check("xor_out_d1", xor_shares(out_sh[1], 3), 8'h07);
    check("count_after_one_d1", cnt[1], 32'd1);
    @(posedge clk); #1;

    // Bypass with randomness offered: copied through, nothing consumed.
    send(1, 40'h0F55AA, 80'h987654, 1'b0, 1'b1, 40'h0F55AA);
    wait_drain(1);
    check("count_after_bypass_d1", cnt[1], 32'd1);

    // Refresh request starved of randomness for three cycles.
    make_rand(3, sh_c, r_c);
    in_sh[1] = sh_c; rnd[1] = r_c; refresh_en[1] = 1'b1; rand_valid[1] = 1'b0; in_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("starved_in_ready_%0d", k), in_ready[1], 1'b0);
      @(posedge clk); #1;
    end
    check("starved_count_d1", cnt[1], 32'd1);
    send(1, sh_c, r_c, 1'b1, 1'b1, model(3, sh_c, r_c, 1'b1));
    wait_drain(1);
    check("count_after_starve_d1", cnt[1], 32'd2);

    // Backpressure: two buffered, third blocked until a pop has completed.
    out_ready[1] = 1'b0;
    rand_send(1, 3, 1);
    rand_send(1, 3, 1);
    make_rand(3, sh_c, r_c);
    e_c = model(3, sh_c, r_c, 1'b1);
    in_sh[1] = sh_c; rnd[1] = r_c; refresh_en[1] = 1'b1; rand_valid[1] = 1'b1; in_valid[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("full_in_ready_%0d", k), in_ready[1], 1'b0);
      check($sformatf("full_rand_ready_%0d", k), rand_ready[1], 1'b0);
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("pop_cycle_in_ready", in_ready[1], 1'b0);
    @(posedge clk); #1;
    send(1, sh_c, r_c, 1'b1, 1'b1, e_c);
    wait_drain(1);
    check("count_after_backpressure_d1", cnt[1], 32'd5);

    // N=5 random stream with mixed modes.
    for (int k = 0; k < 20; k++) rand_send(2, 5, 2);
    wait_drain(2);

    // Reset with two entries buffered.
    out_ready[1] = 1'b0;
    rand_send(1, 3, 1);
    rand_send(1, 3, 2);
    @(negedge clk);
    check("pre_reset_valid_d1", out_valid[1], 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q1.delete();
    @(negedge clk);
    check("post_reset_valid_d1", out_valid[1], 1'b0);
    check("post_reset_count_d1", cnt[1], 32'd0);
    check("post_reset_shares_d1", out_sh[1], 40'h0);
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    send(1, 40'h040201, 80'h402010, 1'b1, 1'b1, 40'h645231);
    @(negedge clk);
    check("post_reset_latency_d1", out_valid[1], 1'b1);
    check("post_reset_count_one_d1", cnt[1], 32'd1);
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) wait_drain(d);
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", out_valid, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
